// File: rtl/fp_align_shifter.sv
// Operand alignment for the FP add/sub path: picks the larger-magnitude operand and right-shifts
// the smaller mantissa with guard/round/sticky collection. Define ALIGN_FAST_FLUSH_EN for a single-cycle full flush.
module fp_align_shifter #(
   parameter int SHIFT_STEP = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        op_sub,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        sign_large,
   output logic [7:0]  exp_large,
   output logic [23:0] mant_large,
   output logic [26:0] mant_small,
   output logic        eff_sub,
   output logic        swapped,
   output logic        special
);
   // state | meaning
   // IDLE  | waiting for operands, in_ready high
   // SHIFT | shifting mant_small right, remaining counts down to zero
   // DONE  | result held on the outputs until out_ready

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [4:0] MAX_SHIFT = 5'd27;
   localparam logic [4:0] STEP      = 5'(SHIFT_STEP);

   state_t      state;
   logic [4:0]  remaining;

   logic [7:0]  exp_a, exp_b, eff_a, eff_b, diff;
   logic        hid_a, hid_b, a_large, is_special;
   logic [22:0] frac_a, frac_b;
   logic [4:0]  d_clamped;

   logic [4:0]  k;
   logic [26:0] mask, shift_mant;
   logic [4:0]  shift_rem;

   assign in_ready = (state == IDLE);

   assign exp_a  = a[30:23];
   assign exp_b  = b[30:23];
   assign frac_a = a[22:0];
   assign frac_b = b[22:0];
   assign hid_a  = (exp_a != 8'd0);
   assign hid_b  = (exp_b != 8'd0);
   assign eff_a  = hid_a ? exp_a : 8'd1;
   assign eff_b  = hid_b ? exp_b : 8'd1;

   // A wins a full tie so equal operands never report a swap
   assign a_large    = (eff_a > eff_b) || ((eff_a == eff_b) && (frac_a >= frac_b));
   assign diff       = a_large ? (eff_a - eff_b) : (eff_b - eff_a);
   assign is_special = (exp_a == 8'hFF) || (exp_b == 8'hFF);
   assign d_clamped  = is_special ? 5'd0 : ((diff > 8'd27) ? MAX_SHIFT : diff[4:0]);

   always_comb begin
      k          = (remaining < STEP) ? remaining : STEP;
      mask       = (27'd1 << k) - 27'd1;
      shift_mant = (mant_small >> k) | {26'd0, |(mant_small & mask)};
      shift_rem  = remaining - k;
`ifdef ALIGN_FAST_FLUSH_EN
      // a 27-bit shift leaves only the sticky bit, so skip the iteration
      if (remaining == MAX_SHIFT) begin
         shift_mant = {26'd0, |mant_small};
         shift_rem  = 5'd0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         remaining  <= 5'd0;
         out_valid  <= 1'b0;
         sign_large <= 1'b0;
         exp_large  <= 8'd0;
         mant_large <= 24'd0;
         mant_small <= 27'd0;
         eff_sub    <= 1'b0;
         swapped    <= 1'b0;
         special    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign_large <= a_large ? a[31] : b[31];
                  exp_large  <= a_large ? eff_a : eff_b;
                  mant_large <= a_large ? {hid_a, frac_a} : {hid_b, frac_b};
                  mant_small <= a_large ? {hid_b, frac_b, 3'b000} : {hid_a, frac_a, 3'b000};
                  eff_sub    <= a[31] ^ b[31] ^ op_sub;
                  swapped    <= ~a_large;
                  special    <= is_special;
                  remaining  <= d_clamped;
                  if (d_clamped == 5'd0) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               mant_small <= shift_mant;
               remaining  <= shift_rem;
               if (shift_rem == 5'd0) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fp_align_shifter.sv
// Bench for fp_align_shifter: directed cases with hand-derived results plus random operands
// checked against a direct (non-iterative) alignment model through an expected-result queue.
module tb_fp_align_shifter;
   localparam int STEP = 4;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, op_sub, out_valid, out_ready;
   logic        sign_large, eff_sub, swapped, special;
   logic [31:0] a, b;
   logic [7:0]  exp_large;
   logic [23:0] mant_large;
   logic [26:0] mant_small;

   typedef struct {
      logic        sign;
      logic [7:0]  ex;
      logic [23:0] ml;
      logic [26:0] ms;
      logic        eff;
      logic        sw;
      logic        sp;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   fp_align_shifter #(.SHIFT_STEP(STEP)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
      .sign_large(sign_large), .exp_large(exp_large), .mant_large(mant_large),
      .mant_small(mant_small), .eff_sub(eff_sub), .swapped(swapped), .special(special)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk(input logic s, input logic [7:0] ex, input logic [23:0] ml,
                               input logic [26:0] ms, input logic eff, input logic sw,
                               input logic sp, input int lat);
      exp_t e;
      e.sign = s; e.ex = ex; e.ml = ml; e.ms = ms;
      e.eff = eff; e.sw = sw; e.sp = sp; e.lat = lat;
      return e;
   endfunction

   function automatic exp_t model(input logic [31:0] av, input logic [31:0] bv, input logic op);
      exp_t        e;
      logic [7:0]  ea, eb;
      logic        a_big;
      int          dd;
      logic [26:0] m, lost;
      ea    = (av[30:23] == 8'd0) ? 8'd1 : av[30:23];
      eb    = (bv[30:23] == 8'd0) ? 8'd1 : bv[30:23];
      a_big = (ea > eb) || ((ea == eb) && (av[22:0] >= bv[22:0]));
      e.sw   = ~a_big;
      e.sign = a_big ? av[31] : bv[31];
      e.ex   = a_big ? ea : eb;
      e.ml   = a_big ? {(av[30:23] != 8'd0), av[22:0]} : {(bv[30:23] != 8'd0), bv[22:0]};
      m      = a_big ? {(bv[30:23] != 8'd0), bv[22:0], 3'b000} : {(av[30:23] != 8'd0), av[22:0], 3'b000};
      e.sp   = (av[30:23] == 8'hFF) || (bv[30:23] == 8'hFF);
      dd     = a_big ? (int'(ea) - int'(eb)) : (int'(eb) - int'(ea));
      if (dd > 27) dd = 27;
      if (e.sp) dd = 0;
      e.ms = m >> dd;
      if (dd > 0) begin
         lost = m << (27 - dd);
         if (lost != 27'd0) e.ms[0] = 1'b1;
      end
      e.eff = av[31] ^ bv[31] ^ op;
      e.lat = 1 + (dd + STEP - 1) / STEP;
`ifdef ALIGN_FAST_FLUSH_EN
      if (dd == 27) e.lat = 2;
`endif
      return e;
   endfunction

   task automatic check_outputs(input string pfx, input exp_t e);
      chk({pfx, "_sign"},    32'(sign_large), 32'(e.sign));
      chk({pfx, "_exp"},     32'(exp_large),  32'(e.ex));
      chk({pfx, "_mlarge"},  32'(mant_large), 32'(e.ml));
      chk({pfx, "_msmall"},  32'(mant_small), 32'(e.ms));
      chk({pfx, "_effsub"},  32'(eff_sub),    32'(e.eff));
      chk({pfx, "_swapped"}, 32'(swapped),    32'(e.sw));
      chk({pfx, "_special"}, 32'(special),    32'(e.sp));
   endtask

   task automatic check_cleared(input string pfx);
      chk({pfx, "_in_ready"},  32'(in_ready),  32'd1);
      chk({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
      check_outputs(pfx, mk(1'b0, 8'd0, 24'd0, 27'd0, 1'b0, 1'b0, 1'b0, 0));
   endtask

   task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic op, input exp_t e, input int stall);
      exp_t got;
      int   n;
      @(negedge clk);
      chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
      a = av; b = bv; op_sub = op; in_valid = 1'b1;
      exp_q.push_back(e);
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 1;
      @(negedge clk);
      while (!out_valid && n < 64) begin
         @(negedge clk);
         n++;
      end
      got = exp_q.pop_front();
      if (!out_valid) begin
         chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
         rst = 1'b1;
         @(posedge clk);
         #1 rst = 1'b0;
         return;
      end
      chk({tag, "_latency"}, 32'(n), 32'(got.lat));
      check_outputs(tag, got);
      for (int i = 0; i < stall; i++) begin
         a = $urandom; b = $urandom; op_sub = ~op; in_valid = 1'b1;
         @(negedge clk);
         chk({tag, "_hold_in_ready"},  32'(in_ready),  32'd0);
         chk({tag, "_hold_out_valid"}, 32'(out_valid), 32'd1);
         check_outputs({tag, "_hold"}, got);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk({tag, "_release_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_release_ready"}, 32'(in_ready),  32'd1);
   endtask

   function automatic logic [31:0] rnd_fp(input logic [7:0] base);
      logic [7:0]  e;
      logic [22:0] f;
      int          r;
      r = int'($urandom_range(0, 9));
      if (r == 0)      e = 8'd0;
      else if (r == 1) e = 8'hFF;
      else if (r < 6)  e = base;
      else             e = 8'($urandom_range(1, 254));
      f = ($urandom_range(0, 4) == 0) ? 23'd0 : 23'($urandom);
      return {1'($urandom), e, f};
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra, rb;
      logic        rop;
      int          base, seen, lat4;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0; a = 32'd0; b = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_cleared("reset");
      rst = 1'b0;

`ifdef ALIGN_FAST_FLUSH_EN
      lat4 = 2;
`else
      lat4 = 8;
`endif

      run_op("c1", 32'h3F800000, 32'h3F800000, 1'b0,
             mk(1'b0, 8'h7F, 24'h800000, 27'h4000000, 1'b0, 1'b0, 1'b0, 1), 0);
      run_op("c2", 32'h3F800000, 32'h40400000, 1'b1,
             mk(1'b0, 8'h80, 24'hC00000, 27'h2000000, 1'b1, 1'b1, 1'b0, 2), 0);
      run_op("c3", 32'h4B800000, 32'h3F800001, 1'b0,
             mk(1'b0, 8'h97, 24'h800000, 27'h0000005, 1'b0, 1'b0, 1'b0, 7), 0);
      run_op("c4", 32'h7F000000, 32'h3F800000, 1'b0,
             mk(1'b0, 8'hFE, 24'h800000, 27'h0000001, 1'b0, 1'b0, 1'b0, lat4), 0);
      run_op("c5", 32'h3F800000, 32'h40400000, 1'b1,
             mk(1'b0, 8'h80, 24'hC00000, 27'h2000000, 1'b1, 1'b1, 1'b0, 2), 5);
      run_op("c6", 32'h7F800000, 32'h3F800000, 1'b0,
             mk(1'b0, 8'hFF, 24'h800000, 27'h4000000, 1'b0, 1'b0, 1'b1, 1), 0);
      run_op("zero", 32'h00000000, 32'h80000000, 1'b0,
             mk(1'b0, 8'h01, 24'h000000, 27'h0000000, 1'b1, 1'b0, 1'b0, 1), 0);

      // abort in the second SHIFT cycle of case 3
      @(negedge clk);
      a = 32'h4B800000; b = 32'h3F800001; op_sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_cleared("abort");
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("abort_no_output", 32'(seen), 32'd0);

      for (int i = 0; i < 40; i++) begin
         ra   = rnd_fp(8'($urandom_range(1, 254)));
         base = int'(ra[30:23]) + int'($urandom_range(0, 60)) - 30;
         if (base < 1) base = 1;
         if (base > 254) base = 254;
         rb  = rnd_fp(8'(base));
         rop = 1'($urandom);
         run_op($sformatf("rnd%0d", i), ra, rb, rop, model(ra, rb, rop), int'($urandom_range(0, 2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
